// File: rtl/byte_serial_comp_ctrl_pkg.sv
// Purpose : shared types and constants for the byte-serial comparator sequencer.
// Contents: FSM state encoding and the cascade seed values loaded at every
//           accepted compare. There are no ports.
package byte_serial_comp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Seed the cascade as "all higher bytes equal" so the MS byte decides alone.
    localparam logic CASC_EQ_INIT = 1'b1;
    localparam logic CASC_GT_INIT = 1'b0;

endpackage

// File: rtl/byte_serial_comp_ctrl_comp_8.sv
// Purpose : 8-bit unsigned magnitude comparator slice with cascade inputs.
//           The cascade inputs carry the result of the more-significant bytes.
// Ports   : i_a, i_b    - byte operands
//           i_eq1, i_gt1 - cascade in (higher bytes equal / A greater so far)
//           o_eq0, o_gt0 - cascade out including this byte
module comp_8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_eq1,
    input  logic       i_gt1,
    output logic       o_eq0,
    output logic       o_gt0
);

    assign o_eq0 = i_eq1 & (i_a == i_b);
    assign o_gt0 = i_gt1 | (i_eq1 & (i_a > i_b));

endmodule

// File: rtl/byte_serial_comp_ctrl.sv
// Purpose : compares two NBYTES-wide unsigned operands one byte per clock,
//           MS byte first, through a single shared comp_8 slice. Stops on the
//           first unequal byte.
// Ports   : i_clock        - system clock, rising edge
//           i_reset        - asynchronous, active-high
//           i_start        - compare request, honoured only when not busy
//           i_a_in, i_b_in - operands, captured on the accepting edge
//           o_busy         - high while comparing
//           o_done         - one-cycle pulse, results valid
//           o_eq/o_gt/o_lt - result flags, held until the next completion
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for i_start
// ST_RUN  | comparing byte r_idx, cascade fed back through r_casc_*
// ST_DONE | one-cycle result strobe; a new start is accepted here too
module byte_serial_comp_ctrl
    import byte_serial_comp_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [8*NBYTES-1:0]   i_a_in,
    input  logic [8*NBYTES-1:0]   i_b_in,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_eq,
    output logic                  o_gt,
    output logic                  o_lt
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t            r_state;
    logic [W-1:0]      r_a_q;
    logic [W-1:0]      r_b_q;
    logic [IDXW-1:0]   r_idx;
    logic              r_casc_eq;
    logic              r_casc_gt;
    logic              r_eq;
    logic              r_gt;
    logic              r_lt;

    logic [7:0]        w_a_byte;
    logic [7:0]        w_b_byte;
    logic              w_eq0;
    logic              w_gt0;

    // Byte mux: shift by 8*idx rather than a variable part-select.
    assign w_a_byte = 8'(r_a_q >> {r_idx, 3'b000});
    assign w_b_byte = 8'(r_b_q >> {r_idx, 3'b000});

    comp_8 u_comp_8 (
        .i_a   (w_a_byte),
        .i_b   (w_b_byte),
        .i_eq1 (r_casc_eq),
        .i_gt1 (r_casc_gt),
        .o_eq0 (w_eq0),
        .o_gt0 (w_gt0)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_idx     <= '0;
            r_casc_eq <= CASC_EQ_INIT;
            r_casc_gt <= CASC_GT_INIT;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_a_q     <= i_a_in;
                        r_b_q     <= i_b_in;
                        r_idx     <= IDXW'(NBYTES - 1);
                        r_casc_eq <= CASC_EQ_INIT;
                        r_casc_gt <= CASC_GT_INIT;
                        r_state   <= ST_RUN;
                    end else begin
                        r_state   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_casc_eq <= w_eq0;
                    r_casc_gt <= w_gt0;
                    // Any unequal byte already decides the magnitude.
                    if ((r_idx == '0) || !w_eq0) begin
                        r_eq    <= w_eq0;
                        r_gt    <= w_gt0;
                        r_lt    <= ~w_eq0 & ~w_gt0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx   <= r_idx - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == ST_RUN);
    assign o_done = (r_state == ST_DONE);
    assign o_eq   = r_eq;
    assign o_gt   = r_gt;
    assign o_lt   = r_lt;

endmodule

// File: tb/tb_byte_serial_comp_ctrl.sv
module tb_byte_serial_comp_ctrl;

    localparam int NB = 4;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_start = 1'b0;
    logic [31:0]   i_a_in  = '0;
    logic [31:0]   i_b_in  = '0;
    logic          o_busy, o_done, o_eq, o_gt, o_lt;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [63:0]   q_ops[$];
    logic [2:0]    hold = 3'b000;
    logic          prev_done = 1'b0;

    byte_serial_comp_ctrl #(.NBYTES(NB)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_start (i_start),
        .i_a_in  (i_a_in),
        .i_b_in  (i_b_in),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_eq    (o_eq),
        .o_gt    (o_gt),
        .o_lt    (o_lt)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Cycles to resolve: MS mismatching byte j finishes after NB-j edges.
    function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
        for (int j = NB - 1; j >= 0; j--)
            if (a[8*j +: 8] != b[8*j +: 8]) return NB - j;
        return NB;
    endfunction

    function automatic logic [2:0] exp_res(input logic [31:0] a, input logic [31:0] b);
        return {a == b, a > b, a < b};
    endfunction

    // Result check on every done, plus pulse-width and spurious-done checks.
    always @(negedge i_clock) begin
        logic [63:0] op;
        if (prev_done) check("done_width", {31'd0, o_done}, 32'd0);
        if (o_done) begin
            if (q_ops.size() == 0) begin
                check("done_spurious", {31'd0, o_done}, 32'd0);
            end else begin
                op = q_ops.pop_front();
                check("result", {29'd0, o_eq, o_gt, o_lt}, {29'd0, exp_res(op[63:32], op[31:0])});
            end
        end
        prev_done = o_done;
    end

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic start_cmp(input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1;
        i_a_in  = a;
        i_b_in  = b;
        q_ops.push_back({a, b});
        @(posedge i_clock); #1;
        i_start = 1'b0;
        i_a_in  = $urandom;
        i_b_in  = $urandom;
    endtask

    // Returns #1 after the edge that raised done (inside the DONE cycle).
    task automatic wait_done(input logic [31:0] a, input logic [31:0] b, input int k0, input string tag);
        int k;
        int busy_cnt;
        int lat;
        lat      = exp_lat(a, b);
        k        = k0;
        busy_cnt = 0;
        while (!o_done && k < 20) begin
            if (o_busy) busy_cnt++;
            check({tag, "_hold"}, {29'd0, o_eq, o_gt, o_lt}, {29'd0, hold});
            @(posedge i_clock); #1;
            k++;
        end
        check({tag, "_latency"}, k, lat);
        check({tag, "_busy_cycles"}, busy_cnt, lat - k0);
        hold = exp_res(a, b);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          mode;
        int          j;

        #12;
        check("reset_state", {27'd0, o_busy, o_done, o_eq, o_gt, o_lt}, 32'd0);
        @(negedge i_clock);
        i_reset = 1'b0;
        @(posedge i_clock); #1;
        check("idle_after_reset", {30'd0, o_busy, o_done}, 32'd0);

        // 1: full-equal
        start_cmp(32'hDEADBEEF, 32'hDEADBEEF);
        wait_done(32'hDEADBEEF, 32'hDEADBEEF, 0, "t1");
        @(posedge i_clock); #1;

        // 2: MSB early exit
        start_cmp(32'h80000000, 32'h7FFFFFFF);
        wait_done(32'h80000000, 32'h7FFFFFFF, 0, "t2");
        @(posedge i_clock); #1;

        // 3 then 6: LSB decides, then back-to-back start in the DONE cycle
        start_cmp(32'h12345600, 32'h12345601);
        wait_done(32'h12345600, 32'h12345601, 0, "t3");
        start_cmp(32'h00000001, 32'h00000002);
        wait_done(32'h00000001, 32'h00000002, 0, "t6");
        @(posedge i_clock); #1;

        // 4: second start while busy is ignored
        start_cmp(32'h00FF0000, 32'h00FE0000);
        i_start = 1'b1;
        i_a_in  = '0;
        i_b_in  = '0;
        @(posedge i_clock); #1;
        i_start = 1'b0;
        wait_done(32'h00FF0000, 32'h00FE0000, 1, "t4");
        @(posedge i_clock); #1;
        check("t4_no_restart", {31'd0, o_busy}, 32'd0);

        // 5: asynchronous reset mid-run
        start_cmp(32'hDEADBEEF, 32'hDEADBEEF);
        @(posedge i_clock); #1;
        @(posedge i_clock); #4;
        q_ops.delete();
        i_reset = 1'b1;
        #1;
        check("t5_async_clear", {27'd0, o_busy, o_done, o_eq, o_gt, o_lt}, 32'd0);
        hold = 3'b000;
        repeat (3) @(posedge i_clock);
        #3;
        i_reset = 1'b0;
        @(posedge i_clock); #1;
        check("t5_idle", {30'd0, o_busy, o_done}, 32'd0);
        start_cmp(32'hDEADBEEF, 32'hDEADBEEE);
        wait_done(32'hDEADBEEF, 32'hDEADBEEE, 0, "t5_after");
        @(posedge i_clock); #1;

        // Randomized compares, some back-to-back
        for (int i = 0; i < 40; i++) begin
            a    = $urandom;
            mode = $urandom_range(0, 2);
            if (mode == 0) begin
                b = $urandom;
            end else if (mode == 1) begin
                b = a;
            end else begin
                j = $urandom_range(0, NB - 1);
                b = a ^ (32'($urandom_range(1, 255)) << (8 * j));
            end
            if ($urandom_range(0, 1) == 1) begin
                a = b ^ a;
                b = b ^ a;
                a = b ^ a;
            end
            start_cmp(a, b);
            wait_done(a, b, 0, "rnd");
            if ($urandom_range(0, 1) == 1) begin
                @(posedge i_clock); #1;
            end
        end
        @(posedge i_clock); #1;
        @(posedge i_clock); #1;
        check("queue_drained", q_ops.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
